// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
// Resolves the hazards the EX forwarding unit cannot: load-use stalls,
// EX redirect flushes, data-memory wait freezes and mul/div occupancy of EX.
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MD_TIMEOUT     = 64,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic                      ex_mem_read,
  input  logic                      ex_redirect,
  input  logic                      ex_md_req,
  input  logic                      md_done,
  input  logic                      me_dmem_req,
  input  logic                      me_dmem_ready,
  output logic                      pc_stall,
  output logic                      if_id_stall,
  output logic                      if_id_flush,
  output logic                      id_ex_stall,
  output logic                      id_ex_flush,
  output logic                      ex_me_stall,
  output logic                      ex_me_flush,
  output logic                      me_wb_flush,
  output logic                      md_start,
  output logic                      md_timeout,
  output logic [CNT_WIDTH-1:0]      stall_cycles
);

  // md_cnt must be able to hold MD_TIMEOUT itself; it saturates at all-ones.
  localparam int MD_CNT_WIDTH = $clog2(MD_TIMEOUT + 1);
  localparam logic [MD_CNT_WIDTH-1:0] MD_CNT_ONE = MD_CNT_WIDTH'(1);
  localparam logic [MD_CNT_WIDTH-1:0] MD_LIMIT   = MD_CNT_WIDTH'(MD_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0]    STALL_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_BUSY  = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [MD_CNT_WIDTH-1:0] md_cnt;
  logic [MD_CNT_WIDTH-1:0] md_cnt_next;

  logic mem_wait;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;

  assign mem_wait = me_dmem_req & ~me_dmem_ready;
  assign rs1_hit  = id_rs1_used & (id_rs1_addr == ex_rd_addr);
  assign rs2_hit  = id_rs2_used & (id_rs2_addr == ex_rd_addr);
  assign load_use = ex_mem_read & (ex_rd_addr != '0) & (rs1_hit | rs2_hit);

  // Next-state and stall/flush decode; everything is held at 0 while in reset.
  // RUN and MEM_WAIT share one decoder: leaving the wait re-runs the RUN
  // priority list on the current inputs, so pending hazards act on release.
  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_stall = 1'b0;
    id_ex_flush = 1'b0;
    ex_me_stall = 1'b0;
    ex_me_flush = 1'b0;
    me_wb_flush = 1'b0;
    md_start    = 1'b0;
    state_next  = state;
    md_cnt_next = md_cnt;
    if (rst_n) begin
      case (state)
        MD_BUSY: begin
          if (md_done) begin
            state_next  = RUN;
            md_cnt_next = '0;
          end else begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
            ex_me_flush = 1'b1;
            if (md_cnt != '1) begin
              md_cnt_next = md_cnt + MD_CNT_ONE;
            end
          end
        end
        default: begin
          if (mem_wait) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
            ex_me_stall = 1'b1;
            me_wb_flush = 1'b1;
            state_next  = MEM_WAIT;
          end else begin
            state_next = RUN;
            if (ex_md_req) begin
              md_start    = 1'b1;
              pc_stall    = 1'b1;
              if_id_stall = 1'b1;
              id_ex_stall = 1'b1;
              ex_me_flush = 1'b1;
              md_cnt_next = MD_CNT_ONE;
              state_next  = MD_BUSY;
            end else if (ex_redirect) begin
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
            end else if (load_use) begin
              pc_stall    = 1'b1;
              if_id_stall = 1'b1;
              id_ex_flush = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // State and mul/div occupancy counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_next;
      md_cnt <= md_cnt_next;
    end
  end

  // Sticky timeout flag: raised once mul/div has occupied EX for MD_TIMEOUT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_timeout <= 1'b0;
    end else if ((state == MD_BUSY) && (md_cnt >= MD_LIMIT)) begin
      md_timeout <= 1'b1;
    end
  end

  // Performance counter of PC-stalled cycles, free-running with wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (pc_stall) begin
      stall_cycles <= stall_cycles + STALL_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl with an abstract reference
// model compared every cycle, plus hand-computed literal expectations.
module tb_hazard_ctrl;

  localparam int TB_MD_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs1_addr = '0;
  logic [4:0] id_rs2_addr = '0;
  logic       id_rs1_used = 1'b0;
  logic       id_rs2_used = 1'b0;
  logic [4:0] ex_rd_addr = '0;
  logic       ex_mem_read = 1'b0;
  logic       ex_redirect = 1'b0;
  logic       ex_md_req = 1'b0;
  logic       md_done = 1'b0;
  logic       me_dmem_req = 1'b0;
  logic       me_dmem_ready = 1'b0;

  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic        ex_me_stall, ex_me_flush, me_wb_flush, md_start, md_timeout;
  logic [31:0] stall_cycles;
  logic [8:0]  dut_ctl;

  int n_compared = 0;
  int n_failed   = 0;

  // Reference model state: only "is mul/div occupying EX" matters for the
  // control decode; memory-wait and run behave identically on each cycle.
  logic        in_md     = 1'b0;
  int          busy_seen = 0;
  logic        m_timeout = 1'b0;
  logic [31:0] m_stall   = '0;

  hazard_ctrl #(
    .REG_ADDR_WIDTH(5),
    .MD_TIMEOUT    (TB_MD_TIMEOUT),
    .CNT_WIDTH     (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .ex_rd_addr   (ex_rd_addr),
    .ex_mem_read  (ex_mem_read),
    .ex_redirect  (ex_redirect),
    .ex_md_req    (ex_md_req),
    .md_done      (md_done),
    .me_dmem_req  (me_dmem_req),
    .me_dmem_ready(me_dmem_ready),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_stall  (id_ex_stall),
    .id_ex_flush  (id_ex_flush),
    .ex_me_stall  (ex_me_stall),
    .ex_me_flush  (ex_me_flush),
    .me_wb_flush  (me_wb_flush),
    .md_start     (md_start),
    .md_timeout   (md_timeout),
    .stall_cycles (stall_cycles)
  );

  assign dut_ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                    ex_me_stall, ex_me_flush, me_wb_flush, md_start};

  // Clock generation, 10 time-unit period.
  always #5 clk = ~clk;

  // Expected control vector, bit order as dut_ctl, from the hazard priority table.
  function automatic logic [8:0] model_ctl(input logic busy);
    logic mw, lu;
    mw = me_dmem_req && !me_dmem_ready;
    lu = ex_mem_read && (ex_rd_addr != 5'd0) &&
         ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
          (id_rs2_used && (id_rs2_addr == ex_rd_addr)));
    if (!rst_n)          return 9'b000000000;
    if (busy)            return md_done ? 9'b000000000 : 9'b110100100;
    if (mw)              return 9'b110101010;
    if (ex_md_req)       return 9'b110100101;
    if (ex_redirect)     return 9'b001010000;
    if (lu)              return 9'b110010000;
    return 9'b000000000;
  endfunction

  // pc_stall is the top bit of the control vector.
  function automatic logic model_pc_stall();
    return model_ctl(in_md) >= 9'd256;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs just after a rising edge, then settle to the falling edge.
  task automatic applyStimulus(input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic [4:0] rd, input logic mrd,
                               input logic redir, input logic mdreq,
                               input logic mddone, input logic dreq,
                               input logic drdy);
    @(posedge clk);
    #1;
    id_rs1_addr   = rs1;
    id_rs1_used   = u1;
    id_rs2_addr   = rs2;
    id_rs2_used   = u2;
    ex_rd_addr    = rd;
    ex_mem_read   = mrd;
    ex_redirect   = redir;
    ex_md_req     = mdreq;
    md_done       = mddone;
    me_dmem_req   = dreq;
    me_dmem_ready = drdy;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reference model update on each rising edge, cleared by the same async reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_md     <= 1'b0;
      busy_seen <= 0;
      m_timeout <= 1'b0;
      m_stall   <= '0;
    end else begin
      if (model_pc_stall()) m_stall <= m_stall + 32'd1;
      if (in_md) begin
        busy_seen <= busy_seen + 1;
        if (busy_seen + 1 >= TB_MD_TIMEOUT) m_timeout <= 1'b1;
        if (md_done) in_md <= 1'b0;
      end else if (!(me_dmem_req && !me_dmem_ready) && ex_md_req) begin
        in_md     <= 1'b1;
        busy_seen <= 0;
      end
    end
  end

  // Every-cycle comparison of the DUT against the reference model.
  always @(negedge clk) begin
    checkOutput("model_ctl", 32'(dut_ctl), 32'(model_ctl(in_md)));
    checkOutput("model_md_timeout", 32'(md_timeout), 32'(m_timeout));
    checkOutput("model_stall_cycles", stall_cycles, m_stall);
  end

  // Bound on total run time.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence with hand-computed expectations.
  initial begin
    // Hazard-looking inputs while in reset must not produce any output.
    id_rs1_addr = 5'd5; id_rs1_used = 1'b1; ex_rd_addr = 5'd5; ex_mem_read = 1'b1;
    me_dmem_req = 1'b1; me_dmem_ready = 1'b0; ex_md_req = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_ctl", 32'(dut_ctl), 32'd0);
    checkOutput("rst_stall_cycles", stall_cycles, 32'd0);
    checkOutput("rst_md_timeout", 32'(md_timeout), 32'd0);
    id_rs1_addr = '0; id_rs1_used = 1'b0; ex_rd_addr = '0; ex_mem_read = 1'b0;
    me_dmem_req = 1'b0; ex_md_req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Load x5 in EX, ID reads rs1=5: one-cycle stall with bubble.
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_pc_stall", 32'(pc_stall), 32'd1);
    checkOutput("lu_if_id_stall", 32'(if_id_stall), 32'd1);
    checkOutput("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
    checkOutput("lu_id_ex_stall", 32'(id_ex_stall), 32'd0);
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_reload_ctl", 32'(dut_ctl), 32'd0);
    checkOutput("lu_stall_cycles", stall_cycles, 32'd1);

    // Load to x0, and unused rs2 match: no stall.
    applyStimulus(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_x0_ctl", 32'(dut_ctl), 32'd0);
    applyStimulus(5'd3, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rs2_unused_ctl", 32'(dut_ctl), 32'd0);
    applyStimulus(5'd3, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rs2_pc_stall", 32'(pc_stall), 32'd1);

    // Redirect together with load-use: redirect wins, PC not stalled.
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("redir_if_id_flush", 32'(if_id_flush), 32'd1);
    checkOutput("redir_id_ex_flush", 32'(id_ex_flush), 32'd1);
    checkOutput("redir_pc_stall", 32'(pc_stall), 32'd0);
    checkOutput("redir_stall_cycles", stall_cycles, 32'd2);

    // Data memory wait for 3 cycles, then release.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("mw_pc_stall", 32'(pc_stall), 32'd1);
      checkOutput("mw_ex_me_stall", 32'(ex_me_stall), 32'd1);
      checkOutput("mw_me_wb_flush", 32'(me_wb_flush), 32'd1);
    end
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("mw_release_ctl", 32'(dut_ctl), 32'd0);
    checkOutput("mw_stall_cycles", stall_cycles, 32'd5);

    // Redirect pending during a wait takes effect only on release.
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("mw_redir_hold_flush", 32'(if_id_flush), 32'd0);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("mw_redir_release_ctl", 32'(dut_ctl), 32'h050);

    // mul/div request pending during a wait starts only on release.
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("mw_md_hold_start", 32'(md_start), 32'd0);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("mw_md_release_ctl", 32'(dut_ctl), 32'h1A5);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("md_quick_done_ctl", 32'(dut_ctl), 32'd0);
    idleCycle();
    checkOutput("md_quick_run_ctl", 32'(dut_ctl), 32'd0);
    checkOutput("md_quick_stall_cycles", stall_cycles, 32'd8);

    // mul/div with 5 busy cycles; a spurious mem wait is ignored while busy.
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("md_start_pulse", 32'(md_start), 32'd1);
    checkOutput("md_start_ctl", 32'(dut_ctl), 32'h1A5);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
                    (k == 3), 1'b0);
      checkOutput("md_busy_ctl", 32'(dut_ctl), 32'h1A4);
      checkOutput("md_busy_timeout", 32'(md_timeout), (k >= 5) ? 32'd1 : 32'd0);
    end
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("md_done_wins_ctl", 32'(dut_ctl), 32'd0);
    idleCycle();
    checkOutput("md_after_ctl", 32'(dut_ctl), 32'd0);
    checkOutput("md_after_stall_cycles", stall_cycles, 32'd14);
    checkOutput("md_timeout_sticky", 32'(md_timeout), 32'd1);

    // Asynchronous reset between edges clears flags and counters at once.
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_ctl", 32'(dut_ctl), 32'd0);
    checkOutput("rst_mid_timeout", 32'(md_timeout), 32'd0);
    checkOutput("rst_mid_stall_cycles", stall_cycles, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // md_done never arrives: timeout after MD_TIMEOUT busy cycles.
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("to_start_pulse", 32'(md_start), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      idleCycle();
      checkOutput("to_busy_pc_stall", 32'(pc_stall), 32'd1);
      checkOutput("to_flag", 32'(md_timeout), (k >= 5) ? 32'd1 : 32'd0);
    end
    checkOutput("to_stall_cycles", stall_cycles, 32'd6);

    // Reset mid-busy with a memory wait on the inputs.
    #1;
    me_dmem_req = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("to_rst_ctl", 32'(dut_ctl), 32'd0);
    checkOutput("to_rst_timeout", 32'(md_timeout), 32'd0);
    checkOutput("to_rst_stall_cycles", stall_cycles, 32'd0);
    me_dmem_req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idleCycle();
    checkOutput("post_rst_ctl", 32'(dut_ctl), 32'd0);
    idleCycle();
    checkOutput("post_rst_stall_cycles", stall_cycles, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
